// File: rtl/sync_filter_array.sv
// Multi-channel level synchronizer with glitch filter, edge pulses and a saturating glitch counter.
// Latency: async_in to sync_raw in DEST_SYNC_FF edges; dest_out and pulses FILTER_CYCLES edges later.
// Backpressure: none; free-running, a new sample is taken on every dest_clk edge.
//
// Ports:
//   dest_clk, dest_rst_n   sole clock, asynchronous active-low reset
//   async_in[WIDTH]        asynchronous level inputs
//   clr_glitch             synchronous clear of glitch_count (wins over same-cycle glitches)
//   sync_raw[WIDTH]        last synchronizer stage, unfiltered
//   dest_out[WIDTH]        filtered level
//   rise_pulse/fall_pulse  registered 1-cycle pulses on dest_out 0->1 / 1->0
//   change_any             OR of all pulse bits
//   glitch_count[GCNT_W]   saturating count of rejected glitches
module sync_filter_array #(
  parameter int WIDTH         = 8,
  parameter int DEST_SYNC_FF  = 2,
  parameter int INIT_SYNC_FF  = 0,
  parameter int FILTER_CYCLES = 4,
  parameter int GCNT_W        = 16
) (
  input  logic              dest_clk,
  input  logic              dest_rst_n,
  input  logic [WIDTH-1:0]  async_in,
  input  logic              clr_glitch,
  output logic [WIDTH-1:0]  sync_raw,
  output logic [WIDTH-1:0]  dest_out,
  output logic [WIDTH-1:0]  rise_pulse,
  output logic [WIDTH-1:0]  fall_pulse,
  output logic              change_any,
  output logic [GCNT_W-1:0] glitch_count
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT_SYNC_FF[0]}};
  localparam int PC_W  = $clog2(WIDTH + 1);
  // One spare bit above the worst-case sum so saturation can be detected without wrap.
  localparam int SUM_W = GCNT_W + PC_W + 1;
  localparam logic [SUM_W-1:0] GMAX = {{(PC_W + 1){1'b0}}, {GCNT_W{1'b1}}};

  logic [WIDTH-1:0]  chain_q [DEST_SYNC_FF];
  logic [WIDTH-1:0]  chain_d [DEST_SYNC_FF];
  logic [CNT_W-1:0]  cnt_q   [WIDTH];
  logic [CNT_W-1:0]  cnt_d   [WIDTH];
  logic [WIDTH-1:0]  dest_out_q, dest_out_d;
  logic [WIDTH-1:0]  rise_pulse_q, rise_pulse_d;
  logic [WIDTH-1:0]  fall_pulse_q, fall_pulse_d;
  logic [GCNT_W-1:0] glitch_count_q, glitch_count_d;

  logic [WIDTH-1:0]  s;
  logic [WIDTH-1:0]  glitch_vec;
  logic [PC_W-1:0]   glitch_num;
  logic [SUM_W-1:0]  glitch_sum;

  assign s = chain_q[DEST_SYNC_FF-1];

  // Plain flop chain: nothing combinational between stages.
  always_comb begin
    chain_d[0] = async_in;
    for (int k = 1; k < DEST_SYNC_FF; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  // Per-channel stability filter. A channel whose count was running and then
  // sees s return to dest_out has rejected a glitch.
  always_comb begin
    dest_out_d   = dest_out_q;
    rise_pulse_d = '0;
    fall_pulse_d = '0;
    glitch_vec   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == dest_out_q[i]) begin
        cnt_d[i]      = '0;
        glitch_vec[i] = (cnt_q[i] != '0);
      end else if (cnt_q[i] == CNT_LAST) begin
        dest_out_d[i]   = s[i];
        cnt_d[i]        = '0;
        rise_pulse_d[i] = s[i];
        fall_pulse_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    glitch_num = '0;
    for (int i = 0; i < WIDTH; i++) begin
      glitch_num = glitch_num + PC_W'(glitch_vec[i]);
    end
    glitch_sum = SUM_W'(glitch_count_q) + SUM_W'(glitch_num);
    if (clr_glitch) begin
      glitch_count_d = '0;
    end else if (glitch_sum > GMAX) begin
      glitch_count_d = {GCNT_W{1'b1}};
    end else begin
      glitch_count_d = glitch_sum[GCNT_W-1:0];
    end
  end

  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      for (int k = 0; k < DEST_SYNC_FF; k++) begin
        chain_q[k] <= INIT_VEC;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      dest_out_q     <= INIT_VEC;
      rise_pulse_q   <= '0;
      fall_pulse_q   <= '0;
      glitch_count_q <= '0;
    end else begin
      for (int k = 0; k < DEST_SYNC_FF; k++) begin
        chain_q[k] <= chain_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      dest_out_q     <= dest_out_d;
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
      glitch_count_q <= glitch_count_d;
    end
  end

  assign sync_raw     = s;
  assign dest_out     = dest_out_q;
  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign change_any   = |(rise_pulse_q | fall_pulse_q);
  assign glitch_count = glitch_count_q;

endmodule

// File: tb/tb_sync_filter_array.sv
// Bench for sync_filter_array: history-based model of the synchronizer/filter plus directed vectors.
// Latency: model outputs are valid after each dest_clk rising edge and compared on the falling edge.
// Backpressure: not applicable; stimulus is driven on falling edges with fixed cycle counts.
module tb_sync_filter_array;

  localparam int W = 8;
  localparam int D = 2;
  localparam int F = 4;

  logic         dest_clk;
  logic         rst_n;
  logic [W-1:0] async_in;
  logic         clr;
  logic         rst_c_n;
  logic [W-1:0] async_c;
  logic         clr_c;

  logic [W-1:0]  a_sraw, a_dout, a_rise, a_fall;
  logic          a_chg;
  logic [15:0]   a_gcnt;
  logic [W-1:0]  b_sraw, b_dout, b_rise, b_fall;
  logic          b_chg;
  logic [3:0]    b_gcnt;
  logic [W-1:0]  c_sraw, c_dout, c_rise, c_fall;
  logic          c_chg;
  logic [15:0]   c_gcnt;

  int n_checks = 0;
  int n_fail   = 0;

  sync_filter_array #(.WIDTH(W), .DEST_SYNC_FF(D), .INIT_SYNC_FF(0), .FILTER_CYCLES(F), .GCNT_W(16)) u_a (
    .dest_clk(dest_clk), .dest_rst_n(rst_n), .async_in(async_in), .clr_glitch(clr),
    .sync_raw(a_sraw), .dest_out(a_dout), .rise_pulse(a_rise), .fall_pulse(a_fall),
    .change_any(a_chg), .glitch_count(a_gcnt));

  sync_filter_array #(.WIDTH(W), .DEST_SYNC_FF(D), .INIT_SYNC_FF(0), .FILTER_CYCLES(F), .GCNT_W(4)) u_b (
    .dest_clk(dest_clk), .dest_rst_n(rst_n), .async_in(async_in), .clr_glitch(clr),
    .sync_raw(b_sraw), .dest_out(b_dout), .rise_pulse(b_rise), .fall_pulse(b_fall),
    .change_any(b_chg), .glitch_count(b_gcnt));

  sync_filter_array #(.WIDTH(W), .DEST_SYNC_FF(D), .INIT_SYNC_FF(1), .FILTER_CYCLES(F), .GCNT_W(16)) u_c (
    .dest_clk(dest_clk), .dest_rst_n(rst_c_n), .async_in(async_c), .clr_glitch(clr_c),
    .sync_raw(c_sraw), .dest_out(c_dout), .rise_pulse(c_rise), .fall_pulse(c_fall),
    .change_any(c_chg), .glitch_count(c_gcnt));

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: keep every sampled input since reset. The synchronized value after
  // edge m is the input sampled at edge m-D+1. A channel accepts a new level at
  // edge n when the synced value seen at each of the last F edges (all after the
  // previous acceptance and after reset) differed from the current level.
  // A glitch is counted at edge n when the synced value is back at the current
  // level but one edge earlier it differed without being accepted.
  logic [W-1:0] samp[$];
  logic [W-1:0] m_dout, m_rise, m_fall, m_sraw;
  int           last_acc[W];
  int           m_gcnt_a, m_gcnt_b;

  function automatic logic [W-1:0] sv(int m);
    int idx;
    idx = m - D + 1;
    if (idx >= 0 && idx < samp.size()) return samp[idx];
    return '0;
  endfunction

  task automatic model_reset();
    samp.delete();
    m_dout = '0; m_rise = '0; m_fall = '0; m_sraw = '0;
    m_gcnt_a = 0; m_gcnt_b = 0;
    for (int i = 0; i < W; i++) last_acc[i] = -1;
  endtask

  task automatic model_step();
    int n, g;
    logic acc;
    logic [W-1:0] prev1, prev2, t;
    n = samp.size();
    g = 0;
    prev1 = sv(n - 1);
    prev2 = sv(n - 2);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      acc = 1'b1;
      for (int j = 0; j < F; j++) begin
        t = sv(n - j - 1);
        if ((n - j) <= last_acc[i] || t[i] == m_dout[i]) acc = 1'b0;
      end
      if (acc) begin
        m_dout[i]   = prev1[i];
        last_acc[i] = n;
        m_rise[i]   = prev1[i];
        m_fall[i]   = ~prev1[i];
      end else if ((n - 1) > last_acc[i] && prev1[i] == m_dout[i] && prev2[i] != m_dout[i]) begin
        g++;
      end
    end
    if (clr) begin
      m_gcnt_a = 0;
      m_gcnt_b = 0;
    end else begin
      m_gcnt_a = (m_gcnt_a + g > 65535) ? 65535 : m_gcnt_a + g;
      m_gcnt_b = (m_gcnt_b + g > 15) ? 15 : m_gcnt_b + g;
    end
    samp.push_back(async_in);
    m_sraw = sv(n);
  endtask

  always @(posedge dest_clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare process: every falling edge, both shared-input instances vs model.
  always @(negedge dest_clk) begin
    check("a_sync_raw", a_sraw, m_sraw);
    check("a_dest_out", a_dout, m_dout);
    check("a_rise", a_rise, m_rise);
    check("a_fall", a_fall, m_fall);
    check("a_change_any", a_chg, |(m_rise | m_fall));
    check("a_glitch_count", a_gcnt, m_gcnt_a[15:0]);
    check("b_dest_out", b_dout, m_dout);
    check("b_glitch_count", b_gcnt, m_gcnt_b[3:0]);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge dest_clk);
  endtask

  logic [W-1:0] fall_acc;

  initial begin
    rst_n = 1'b0; rst_c_n = 1'b0;
    async_in = '0; clr = 1'b0;
    async_c = 8'hFF; clr_c = 1'b0;
    tick(3);
    check("reset_dest_out", a_dout, 8'h00);
    check("reset_c_dest_out", c_dout, 8'hFF);
    rst_n = 1'b1; rst_c_n = 1'b1;

    // Idle after release; INIT=1 instance sees matching all-ones input.
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("idle_dest_out", a_dout, 8'h00);
      check("idle_pulses", a_rise | a_fall, 8'h00);
      check("idle_gcnt", a_gcnt, 16'd0);
      check("init1_dest_out", c_dout, 8'hFF);
      check("init1_pulses", c_rise | c_fall, 8'h00);
    end

    // Single rise on channel 3: edge 0 sample, s at edge 1, dest_out at edge 5.
    async_in[3] = 1'b1;
    tick(1);
    check("ch3_sraw_e0", a_sraw, 8'h00);
    tick(1);
    check("ch3_sraw_e1", a_sraw, 8'h08);
    tick(3);
    check("ch3_dout_e4", a_dout, 8'h00);
    tick(1);
    check("ch3_dout_e5", a_dout, 8'h08);
    check("ch3_rise_e5", a_rise, 8'h08);
    check("ch3_change_e5", a_chg, 1'b1);
    tick(1);
    check("ch3_rise_e6", a_rise, 8'h00);

    // Two-cycle glitch on channel 5 is rejected and counted.
    async_in[5] = 1'b1;
    tick(2);
    async_in[5] = 1'b0;
    tick(8);
    check("ch5_glitch_cnt", a_gcnt, 16'd1);
    check("ch5_glitch_dout", a_dout, 8'h08);
    // Four cycles high is accepted, then falls back; no new glitch.
    async_in[5] = 1'b1;
    tick(4);
    async_in[5] = 1'b0;
    tick(12);
    check("ch5_pulse_cnt", a_gcnt, 16'd1);
    check("ch5_pulse_dout", a_dout, 8'h08);

    // Three simultaneous glitches add 3 in one cycle.
    async_in[2:0] = 3'b111;
    tick(2);
    async_in[2:0] = 3'b000;
    tick(8);
    check("multi_glitch_cnt", a_gcnt, 16'd4);
    // Same glitch with clear on the counting edge: clear wins.
    async_in[2:0] = 3'b111;
    tick(2);
    async_in[2:0] = 3'b000;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_wins_cnt", a_gcnt, 16'd0);
    tick(6);
    check("clr_after_cnt", a_gcnt, 16'd0);

    // Twenty single-channel glitches: 16-bit counter reaches 20, 4-bit saturates.
    for (int k = 0; k < 20; k++) begin
      async_in[6] = 1'b1;
      tick(2);
      async_in[6] = 1'b0;
      tick(4);
    end
    tick(4);
    check("sat_a_cnt", a_gcnt, 16'd20);
    check("sat_b_cnt", b_gcnt, 4'd15);

    // Reset in the middle of a falling transition on channel 0.
    async_in[0] = 1'b1;
    tick(8);
    check("ch0_high", a_dout, 8'h09);
    async_in[0] = 1'b0;
    tick(4);
    check("ch0_midfall", a_dout, 8'h09);
    #2;
    rst_n = 1'b0;
    async_in = '0;
    #1;
    check("async_rst_dout", a_dout, 8'h00);
    check("async_rst_sraw", a_sraw, 8'h00);
    check("async_rst_gcnt", a_gcnt, 16'd0);
    tick(3);
    rst_n = 1'b1;
    fall_acc = '0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      fall_acc = fall_acc | a_fall;
    end
    check("post_rst_no_fall", fall_acc, 8'h00);
    check("post_rst_dout", a_dout, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
